// File: rtl/addsub_digit_serial_if.sv
// Request/result bundle for the digit-serial adder/subtractor.
// The master issues start with operands and controls; the slave returns status and result.
interface addsub_digit_serial_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             sgn;
  logic             sat;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;
  logic             zero;

  modport master (
    output start, a, b, sub, sgn, sat,
    input  busy, done, result, carry_out, overflow, zero
  );

  modport slave (
    input  start, a, b, sub, sgn, sat,
    output busy, done, result, carry_out, overflow, zero
  );
endinterface

// File: rtl/addsub_digit_serial.sv
// Digit-serial add/subtract: WIDTH/DIGIT cycles per operation, LS digit first.
// Produces carry/borrow, signed or unsigned overflow, optional saturation and zero flag.
module addsub_digit_serial #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  addsub_digit_serial_if.slave bus
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] acc;
  logic             a_msb;
  logic             b_msb;
  logic             sub_q;
  logic             sgn_q;
  logic             sat_q;
  logic             carry_q;
  logic [CW-1:0]    cnt;

  logic [DIGIT:0]   dsum;
  logic [WIDTH-1:0] raw_next;
  logic [WIDTH-1:0] sat_val;
  logic [WIDTH-1:0] res_next;
  logic             last;
  logic             cout;
  logic             ovf_s;
  logic             ovf;

  always_comb begin
    dsum     = {1'b0, op_a[DIGIT-1:0]} + {1'b0, op_b[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
    // Sum digits enter at the top and shift down, so after N digits acc is LSB-aligned.
    raw_next = (acc >> DIGIT) | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));
    last     = (cnt == CW'(N - 1));
    cout     = dsum[DIGIT] ^ sub_q;
    ovf_s    = (a_msb == b_msb) && (raw_next[WIDTH-1] != a_msb);
    ovf      = sgn_q ? ovf_s : cout;
    if (sgn_q) begin
      sat_val = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      sat_val = sub_q ? '0 : '1;
    end
    res_next = (sat_q && ovf) ? sat_val : raw_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      op_a          <= '0;
      op_b          <= '0;
      acc           <= '0;
      a_msb         <= 1'b0;
      b_msb         <= 1'b0;
      sub_q         <= 1'b0;
      sgn_q         <= 1'b0;
      sat_q         <= 1'b0;
      carry_q       <= 1'b0;
      cnt           <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.result    <= '0;
      bus.carry_out <= 1'b0;
      bus.overflow  <= 1'b0;
      bus.zero      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            op_a     <= bus.a;
            op_b     <= bus.b ^ {WIDTH{bus.sub}};
            a_msb    <= bus.a[WIDTH-1];
            b_msb    <= bus.b[WIDTH-1] ^ bus.sub;
            sub_q    <= bus.sub;
            sgn_q    <= bus.sgn;
            sat_q    <= bus.sat;
            carry_q  <= bus.sub;
            cnt      <= '0;
            acc      <= '0;
            bus.busy <= 1'b1;
            state    <= BUSY;
          end else begin
            state <= IDLE;
          end
        end
        BUSY: begin
          op_a    <= op_a >> DIGIT;
          op_b    <= op_b >> DIGIT;
          acc     <= raw_next;
          carry_q <= dsum[DIGIT];
          cnt     <= cnt + CW'(1);
          if (last) begin
            state         <= DONE;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b1;
            bus.result    <= res_next;
            bus.carry_out <= cout;
            bus.overflow  <= ovf;
            bus.zero      <= (res_next == '0);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_addsub_digit_serial.sv
// Self-checking bench for addsub_digit_serial: directed table, handshake/reset
// sequences and randomized operations against an arithmetic reference model.
module tb_addsub_digit_serial;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  addsub_digit_serial_if #(.WIDTH(16)) if16 ();
  addsub_digit_serial_if #(.WIDTH(8))  if8a ();
  addsub_digit_serial_if #(.WIDTH(8))  if8b ();

  addsub_digit_serial #(.WIDTH(16), .DIGIT(4)) u16  (.clk(clk), .rst_n(rst_n), .bus(if16.slave));
  addsub_digit_serial #(.WIDTH(8),  .DIGIT(8)) u8a  (.clk(clk), .rst_n(rst_n), .bus(if8a.slave));
  addsub_digit_serial #(.WIDTH(8),  .DIGIT(1)) u8b  (.clk(clk), .rst_n(rst_n), .bus(if8b.slave));

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        sgn;
    logic        sat;
    logic [15:0] res;
    logic        co;
    logic        ov;
    logic        z;
  } vec_t;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %h required %h", name, act, exp);
  endtask

  task automatic drive(input int inst, input logic st, input logic [15:0] a, input logic [15:0] b,
                       input logic sub, input logic sgn, input logic sat);
    case (inst)
      0: begin
        if16.start = st; if16.a = a; if16.b = b; if16.sub = sub; if16.sgn = sgn; if16.sat = sat;
      end
      1: begin
        if8a.start = st; if8a.a = a[7:0]; if8a.b = b[7:0]; if8a.sub = sub; if8a.sgn = sgn; if8a.sat = sat;
      end
      default: begin
        if8b.start = st; if8b.a = a[7:0]; if8b.b = b[7:0]; if8b.sub = sub; if8b.sgn = sgn; if8b.sat = sat;
      end
    endcase
  endtask

  // Packed view: {result[15:0], carry_out, overflow, zero}
  task automatic sample(input int inst, output logic bz, output logic dn, output logic [18:0] pk);
    case (inst)
      0: begin
        bz = if16.busy; dn = if16.done;
        pk = {if16.result, if16.carry_out, if16.overflow, if16.zero};
      end
      1: begin
        bz = if8a.busy; dn = if8a.done;
        pk = {8'h00, if8a.result, if8a.carry_out, if8a.overflow, if8a.zero};
      end
      default: begin
        bz = if8b.busy; dn = if8b.done;
        pk = {8'h00, if8b.result, if8b.carry_out, if8b.overflow, if8b.zero};
      end
    endcase
  endtask

  // Waits from the current cycle until done; cyc counts cycles, -1 on timeout.
  task automatic wait_done(input int inst, inout int cyc, output logic [18:0] pk, output logic busy_ok);
    logic bz, dn;
    busy_ok = 1'b1;
    sample(inst, bz, dn, pk);
    while (!dn && cyc < 60) begin
      if (!bz) busy_ok = 1'b0;
      @(negedge clk);
      cyc++;
      sample(inst, bz, dn, pk);
    end
    if (!dn) cyc = -1;
    if (bz) busy_ok = 1'b0;
  endtask

  task automatic do_op(input int inst, input logic [15:0] a, input logic [15:0] b, input logic sub,
                       input logic sgn, input logic sat, output logic [18:0] pk, output int lat,
                       output logic busy_ok);
    drive(inst, 1'b1, a, b, sub, sgn, sat);
    @(negedge clk);
    drive(inst, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    lat = 1;
    wait_done(inst, lat, pk, busy_ok);
  endtask

  function automatic logic [18:0] model(input int w, input logic [15:0] a, input logic [15:0] b,
                                        input logic sub, input logic sgn, input logic sat);
    longint m    = (longint'(1) << w) - 1;
    longint half = longint'(1) << (w - 1);
    longint ua   = longint'(a) & m;
    longint ub   = longint'(b) & m;
    longint sa   = (ua >= half) ? ua - (m + 1) : ua;
    longint sb   = (ub >= half) ? ub - (m + 1) : ub;
    longint s, raw, r;
    logic   co, ov, sov;
    if (sub) begin
      co = ua < ub; raw = (ua - ub) & m; s = sa - sb;
    end else begin
      co = (ua + ub) > m; raw = (ua + ub) & m; s = sa + sb;
    end
    sov = (s >= half) || (s < -half);
    ov  = sgn ? sov : co;
    r   = raw;
    if (sat && ov) begin
      if (sgn) r = (sa < 0) ? half : half - 1;
      else     r = sub ? 0 : m;
    end
    return {r[15:0], co, ov, (r == 0)};
  endfunction

  vec_t        tbl [10];
  logic [18:0] pk;
  logic        busy_ok, bz, dn, seen;
  int          lat, cyc;
  logic [15:0] ra, rb;
  logic        rsub, rsgn, rsat;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{16'h1234, 16'h0FFF, 1'b0, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
    tbl[2] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{16'h0005, 16'h0007, 1'b1, 1'b0, 1'b0, 16'hFFFE, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{16'h0005, 16'h0007, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b1};
    tbl[5] = '{16'h0007, 16'h0005, 1'b1, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{16'h7FFF, 16'h0001, 1'b0, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{16'h7FFF, 16'h0001, 1'b0, 1'b1, 1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b0};
    tbl[8] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0};
    tbl[9] = '{16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};

    for (int i = 0; i < 3; i++) drive(i, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    sample(0, bz, dn, pk);
    check("reset_state", {11'h0, bz, dn, pk}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      do_op(0, tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].sgn, tbl[i].sat, pk, lat, busy_ok);
      check($sformatf("vec%0d_outputs", i), {13'h0, pk}, {13'h0, tbl[i].res, tbl[i].co, tbl[i].ov, tbl[i].z});
      check($sformatf("vec%0d_latency_busy", i), {busy_ok, 31'(lat)}, {1'b1, 31'd5});
      @(negedge clk);
    end

    // start pulsed in cycle 2 while busy must be ignored
    drive(0, 1'b1, 16'h1234, 16'h0FFF, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    drive(0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    drive(0, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    drive(0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    cyc = 3;
    wait_done(0, cyc, pk, busy_ok);
    check("ignored_start_result", {13'h0, pk}, {13'h0, 16'h2233, 3'b000});
    check("ignored_start_done_cycle", 32'(cyc), 32'd5);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      sample(0, bz, dn, pk);
      if (bz || dn) seen = 1'b1;
    end
    check("ignored_start_no_extra_op", {31'h0, seen}, 32'h0);

    // start in the done cycle: back-to-back
    do_op(0, 16'h1234, 16'h0FFF, 1'b0, 1'b0, 1'b0, pk, lat, busy_ok);
    check("b2b_first_result", {13'h0, pk}, {13'h0, 16'h2233, 3'b000});
    do_op(0, 16'h0007, 16'h0005, 1'b1, 1'b0, 1'b0, pk, lat, busy_ok);
    check("b2b_second_result", {13'h0, pk}, {13'h0, 16'h0002, 3'b000});
    check("b2b_second_latency", {busy_ok, 31'(lat)}, {1'b1, 31'd5});

    // reset in cycle 2 of an operation aborts it
    drive(0, 1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    drive(0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    sample(0, bz, dn, pk);
    check("midop_reset_outputs", {11'h0, bz, dn, pk}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      sample(0, bz, dn, pk);
      if (bz || dn) seen = 1'b1;
    end
    check("midop_reset_no_done", {31'h0, seen}, 32'h0);
    do_op(0, 16'h0007, 16'h0005, 1'b1, 1'b0, 1'b0, pk, lat, busy_ok);
    check("post_reset_op", {lat[12:0], pk}, {13'd5, 16'h0002, 3'b000});
    @(negedge clk);

    // single-digit and bit-serial variants
    do_op(1, 16'h007F, 16'h0001, 1'b0, 1'b1, 1'b0, pk, lat, busy_ok);
    check("w8d8_outputs", {13'h0, pk}, {13'h0, 16'h0080, 3'b010});
    check("w8d8_latency", {busy_ok, 31'(lat)}, {1'b1, 31'd2});
    do_op(2, 16'h0005, 16'h0007, 1'b1, 1'b0, 1'b1, pk, lat, busy_ok);
    check("w8d1_outputs", {13'h0, pk}, {13'h0, 16'h0000, 3'b111});
    check("w8d1_latency", {busy_ok, 31'(lat)}, {1'b1, 31'd9});

    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      rsub = 1'($urandom); rsgn = 1'($urandom); rsat = 1'($urandom);
      do_op(0, ra, rb, rsub, rsgn, rsat, pk, lat, busy_ok);
      check($sformatf("rand16 a=%h b=%h sub=%b sgn=%b sat=%b", ra, rb, rsub, rsgn, rsat),
            {busy_ok, lat[11:0], pk}, {1'b1, 12'd5, model(16, ra, rb, rsub, rsgn, rsat)});
    end

    for (int inst = 1; inst < 3; inst++) begin
      for (int i = 0; i < 150; i++) begin
        ra = {8'h00, 8'($urandom)}; rb = {8'h00, 8'($urandom)};
        rsub = 1'($urandom); rsgn = 1'($urandom); rsat = 1'($urandom);
        do_op(inst, ra, rb, rsub, rsgn, rsat, pk, lat, busy_ok);
        check($sformatf("rand8_inst%0d a=%h b=%h sub=%b sgn=%b sat=%b", inst, ra[7:0], rb[7:0], rsub, rsgn, rsat),
              {busy_ok, lat[11:0], pk},
              {1'b1, (inst == 1) ? 12'd2 : 12'd9, model(8, ra, rb, rsub, rsgn, rsat)});
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
